// File: rtl/detector_jogada_if.sv
// Bus bundle between the game controller and the play detector.
// Raw buttons and control go in; the accepted play and its status pulses come out.
interface detector_jogada_if;
    logic       enable;
    logic       limpa;
    logic [3:0] botoes;
    logic [3:0] jogada;
    logic       tem_jogada;
    logic       multipla;
    logic [2:0] db_estado;

    modport master (
        output enable, limpa, botoes,
        input  jogada, tem_jogada, multipla, db_estado
    );

    modport slave (
        input  enable, limpa, botoes,
        output jogada, tem_jogada, multipla, db_estado
    );
endinterface

// File: rtl/detector_jogada.sv
// Button conditioning for the game: synchronise, debounce press and release,
// accept exactly one pressed button per play and flag multiple presses.
module detector_jogada #(
    parameter int DEBOUNCE = 3,
    parameter int CNT_W    = 4
) (
    input  logic              clock,
    input  logic              reset,
    detector_jogada_if.slave  bus
);

    typedef enum logic [2:0] {
        OCIOSO = 3'd0,
        FILTRA = 3'd1,
        VALIDO = 3'd2,
        MULTI  = 3'd3,
        SOLTA  = 3'd4
    } estado_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

    estado_t          estado_q, estado_d;
    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       cap_q, cap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       jogada_q, jogada_d;
    logic [3:0]       bs;
    logic             capOneHot;

    assign bs        = sync2_q;
    assign capOneHot = (cap_q != 4'b0000) && ((cap_q & (cap_q - 4'd1)) == 4'b0000);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 4'b0000;
            sync2_q  <= 4'b0000;
            estado_q <= OCIOSO;
            cap_q    <= 4'b0000;
            cnt_q    <= '0;
            jogada_q <= 4'b0000;
        end else begin
            sync1_q  <= bus.botoes;
            sync2_q  <= sync1_q;
            estado_q <= estado_d;
            cap_q    <= cap_d;
            cnt_q    <= cnt_d;
            jogada_q <= jogada_d;
        end
    end

    // limpa clears jogada unless a new play is accepted on the same edge.
    always_comb begin
        estado_d = estado_q;
        cap_d    = cap_q;
        cnt_d    = cnt_q;
        jogada_d = bus.limpa ? 4'b0000 : jogada_q;

        case (estado_q)
            OCIOSO: begin
                if (bs != 4'b0000) begin
                    cnt_d = '0;
                    if (bus.enable) begin
                        estado_d = FILTRA;
                        cap_d    = bs;
                    end else begin
                        estado_d = SOLTA;
                    end
                end
            end
            FILTRA: begin
                if (!bus.enable) begin
                    estado_d = SOLTA;
                    cnt_d    = '0;
                end else if (bs == 4'b0000) begin
                    estado_d = OCIOSO;
                end else if (bs != cap_q) begin
                    cap_d = bs;
                    cnt_d = '0;
                end else if (cnt_q < CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (capOneHot) begin
                    estado_d = VALIDO;
                    jogada_d = cap_q;
                end else begin
                    estado_d = MULTI;
                end
            end
            VALIDO, MULTI: begin
                estado_d = SOLTA;
                cnt_d    = '0;
            end
            SOLTA: begin
                if (bs != 4'b0000) begin
                    cnt_d = '0;
                end else if (cnt_q >= CNT_MAX) begin
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                estado_d = OCIOSO;
                cnt_d    = '0;
            end
        endcase
    end

    assign bus.jogada     = jogada_q;
    assign bus.tem_jogada = (estado_q == VALIDO);
    assign bus.multipla   = (estado_q == MULTI);
    assign bus.db_estado  = estado_q;

endmodule

// File: tb/tb_detector_jogada.sv
// Self-checking bench for detector_jogada: vector table, directed corner
// sequences and randomized button activity against a behavioural model.
module tb_detector_jogada;

    localparam int DEBOUNCE = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #10 clock = ~clock;

    detector_jogada_if bus ();

    detector_jogada #(.DEBOUNCE(DEBOUNCE), .CNT_W(4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int pulseCount = 0;
    int multiCount = 0;

    // Behavioural model: runs of identical synchronised samples decide plays.
    logic [3:0] mSyncA, mSyncB, mRunVal, mJog;
    int         mRunLen, mZeros, mPulse;
    bit         mReleasing;

    typedef struct {
        logic [3:0] botoes;
        logic       enable;
        int         hold;
        int         expPulses;
        int         expMulti;
        logic [3:0] expJog;
    } vector_t;

    vector_t vecs [8];

    task automatic modelReset();
        mSyncA = 4'b0; mSyncB = 4'b0; mRunVal = 4'b0; mJog = 4'b0;
        mRunLen = 0; mZeros = 0; mPulse = 0; mReleasing = 1'b0;
    endtask

    task automatic modelEdge();
        logic [3:0] bs;
        logic [3:0] newJog;
        bs     = mSyncB;
        mSyncB = mSyncA;
        mSyncA = bus.botoes;
        newJog = bus.limpa ? 4'b0 : mJog;
        if (mPulse != 0) begin
            mPulse = 0; mReleasing = 1'b1; mZeros = 0;
        end else if (mReleasing) begin
            if (bs != 4'b0) mZeros = 0;
            else begin
                mZeros++;
                if (mZeros == DEBOUNCE) begin mReleasing = 1'b0; mRunLen = 0; end
            end
        end else if (mRunLen > 0 && !bus.enable) begin
            mReleasing = 1'b1; mZeros = 0; mRunLen = 0;
        end else if (bs == 4'b0) begin
            mRunLen = 0;
        end else if (mRunLen == 0) begin
            if (bus.enable) begin mRunVal = bs; mRunLen = 1; end
            else begin mReleasing = 1'b1; mZeros = 0; end
        end else if (bs != mRunVal) begin
            mRunVal = bs; mRunLen = 1;
        end else begin
            mRunLen++;
            if (mRunLen == DEBOUNCE + 1) begin
                mRunLen = 0;
                if ($countones(mRunVal) == 1) begin mPulse = 1; newJog = mRunVal; end
                else mPulse = 2;
            end
        end
        mJog = newJog;
    endtask

    function automatic int modelState();
        if (mPulse == 1) return 2;
        if (mPulse == 2) return 3;
        if (mReleasing)  return 4;
        if (mRunLen > 0) return 1;
        return 0;
    endfunction

    task automatic compare(input string what, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d required %0d (t=%0t)", what, got, want, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, ".tem_jogada"}, int'(bus.tem_jogada), (mPulse == 1) ? 1 : 0);
        compare({tag, ".multipla"},   int'(bus.multipla),   (mPulse == 2) ? 1 : 0);
        compare({tag, ".jogada"},     int'(bus.jogada),     int'(mJog));
        compare({tag, ".db_estado"},  int'(bus.db_estado),  modelState());
        pulseCount += int'(bus.tem_jogada);
        multiCount += int'(bus.multipla);
    endtask

    // One clock: model steps on the rising edge, outputs compared on the falling edge.
    task automatic applyStimulus(input logic [3:0] b, input logic en, input logic lp,
                                 input int cycles, input string tag);
        for (int i = 0; i < cycles; i++) begin
            bus.botoes = b; bus.enable = en; bus.limpa = lp;
            @(posedge clock);
            modelEdge();
            @(negedge clock);
            checkOutput(tag);
        end
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b0;
        bus.botoes = 4'b0; bus.enable = 1'b1; bus.limpa = 1'b0;
        modelReset();
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int firstPulse;
        bus.botoes = 4'b0; bus.enable = 1'b1; bus.limpa = 1'b0;
        modelReset();

        vecs[0] = '{4'b0010, 1'b1, 10, 1, 0, 4'b0010};
        vecs[1] = '{4'b0101, 1'b1, 10, 0, 1, 4'b0010};
        vecs[2] = '{4'b1000, 1'b0, 10, 0, 0, 4'b0010};
        vecs[3] = '{4'b0001, 1'b1,  2, 0, 0, 4'b0010};
        vecs[4] = '{4'b0001, 1'b1,  3, 0, 0, 4'b0010};
        vecs[5] = '{4'b0001, 1'b1,  4, 1, 0, 4'b0001};
        vecs[6] = '{4'b1111, 1'b1, 10, 0, 1, 4'b0001};
        vecs[7] = '{4'b0100, 1'b1, 10, 1, 0, 4'b0100};

        // Reset state, checked against constants while reset is held.
        @(negedge clock);
        @(negedge clock);
        compare("reset.jogada",     int'(bus.jogada),     0);
        compare("reset.tem_jogada", int'(bus.tem_jogada), 0);
        compare("reset.multipla",   int'(bus.multipla),   0);
        compare("reset.db_estado",  int'(bus.db_estado),  0);
        reset = 1'b1;

        // Vector table: hold a pattern, release, count pulses.
        for (int v = 0; v < 8; v++) begin
            pulseCount = 0; multiCount = 0;
            applyStimulus(vecs[v].botoes, vecs[v].enable, 1'b0, vecs[v].hold, "vec");
            applyStimulus(4'b0, 1'b1, 1'b0, 6, "vecRel");
            compare($sformatf("vec%0d.pulses", v), pulseCount, vecs[v].expPulses);
            compare($sformatf("vec%0d.multi", v),  multiCount, vecs[v].expMulti);
            compare($sformatf("vec%0d.jogada", v), int'(bus.jogada), int'(vecs[v].expJog));
            compare($sformatf("vec%0d.idle", v),   int'(bus.db_estado), 0);
        end

        // Latency: one-hot press stable before edge 0 pulses after edge 5.
        firstPulse = -1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0010, 1'b1, 1'b0, 1, "latency");
            if (bus.tem_jogada && firstPulse < 0) firstPulse = i;
        end
        compare("latency.edge", firstPulse, 5);
        applyStimulus(4'b0, 1'b1, 1'b0, 6, "latencyRel");

        // Bounce: pulse comes 5 edges after the last restart.
        pulseCount = 0; firstPulse = -1;
        for (int i = 0; i < 16; i++) begin
            applyStimulus((i == 2 || i >= 13) ? 4'b0000 : 4'b0100, 1'b1, 1'b0, 1, "bounce");
            if (bus.tem_jogada && firstPulse < 0) firstPulse = i;
        end
        compare("bounce.edge", firstPulse, 8);
        compare("bounce.pulses", pulseCount, 1);
        compare("bounce.jogada", int'(bus.jogada), 4);

        // Enable rises while a button is held: that press must be ignored.
        pulseCount = 0;
        applyStimulus(4'b1000, 1'b0, 1'b0, 4, "enLow");
        applyStimulus(4'b1000, 1'b1, 1'b0, 8, "enRise");
        applyStimulus(4'b0000, 1'b1, 1'b0, 4, "enRel");
        compare("enRise.pulses", pulseCount, 0);
        applyStimulus(4'b1000, 1'b1, 1'b0, 10, "enPress");
        applyStimulus(4'b0000, 1'b1, 1'b0, 6, "enPressRel");
        compare("enPress.pulses", pulseCount, 1);
        compare("enPress.jogada", int'(bus.jogada), 8);

        // Short press then limpa.
        pulseCount = 0;
        applyStimulus(4'b0001, 1'b1, 1'b0, 2, "short");
        applyStimulus(4'b0000, 1'b1, 1'b0, 6, "shortRel");
        compare("short.pulses", pulseCount, 0);
        applyStimulus(4'b0000, 1'b1, 1'b1, 1, "limpa");
        compare("limpa.jogada", int'(bus.jogada), 0);

        // limpa held across an accepted play: the new play wins on that edge.
        applyStimulus(4'b0100, 1'b1, 1'b1, 8, "limpaWin");
        applyStimulus(4'b0000, 1'b1, 1'b0, 6, "limpaWinRel");

        // Asynchronous reset while filtering.
        applyStimulus(4'b0010, 1'b1, 1'b0, 3, "preReset");
        compare("preReset.db_estado", int'(bus.db_estado), 1);
        #3;
        reset = 1'b0;
        bus.botoes = 4'b0;
        #1;
        compare("asyncReset.jogada",     int'(bus.jogada),     0);
        compare("asyncReset.tem_jogada", int'(bus.tem_jogada), 0);
        compare("asyncReset.multipla",   int'(bus.multipla),   0);
        compare("asyncReset.db_estado",  int'(bus.db_estado),  0);
        modelReset();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        pulseCount = 0;
        applyStimulus(4'b0000, 1'b1, 1'b0, 8, "postReset");
        compare("postReset.pulses", pulseCount, 0);

        // Randomized button activity with occasional enable drops and limpa.
        for (int seg = 0; seg < 300; seg++) begin
            logic [3:0] val;
            int         len;
            case ($urandom_range(0, 3))
                0, 1:    val = 4'b0;
                2:       val = 4'(1 << $urandom_range(0, 3));
                default: val = 4'($urandom_range(1, 15));
            endcase
            len = $urandom_range(1, 8);
            for (int c = 0; c < len; c++)
                applyStimulus(val, ($urandom_range(0, 9) != 0), ($urandom_range(0, 19) == 0), 1, "random");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
